// File: rtl/shift_rows.sv
// shift_rows: registered AES ShiftRows/InvShiftRows byte permutation, 1 or 2 register stages.
module shift_rows #(
  parameter int PIPE_STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         inverse,
  input  logic [127:0] data_in,
  output logic         out_valid,
  output logic [127:0] data_out
);
  logic [127:0] perm, d1;
  logic         v1;
  // Source byte index for output byte k: row r = k%4 pulls from column (c +/- r) mod 4.
  function automatic int src(input int k, input logic inv);
    return 4 * ((inv ? k / 4 - k % 4 + 4 : k / 4 + k % 4) % 4) + k % 4;
  endfunction
  always_comb begin
    perm = '0;
    for (int k = 0; k < 16; k++) perm[127 - 8 * k -: 8] = data_in[127 - 8 * src(k, inverse) -: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) d1 <= perm;
    end
  end
  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign data_out  = d1;
      assign out_valid = v1;
    end else if (PIPE_STAGES == 2) begin : g_two
      logic [127:0] d2;
      logic         v2;
      always_ff @(posedge clk) begin
        if (rst) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign data_out  = d2;
      assign out_valid = v2;
    end else begin : g_bad
      $error("shift_rows: PIPE_STAGES must be 1 or 2");
    end
  endgenerate
endmodule

// File: tb/tb_shift_rows.sv
// tb_shift_rows: directed vectors, reset corner cases and random beats on 1- and 2-stage instances.
module tb_shift_rows;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic inverse = 1'b0;
  logic [127:0] data_in = '0;
  logic ov1, ov2;
  logic [127:0] do1, do2;
  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  logic m1v, m2v;
  logic [127:0] m1d, m2d;

  always #5 clk = ~clk;

  shift_rows #(.PIPE_STAGES(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .inverse(inverse),
    .data_in(data_in), .out_valid(ov1), .data_out(do1));
  shift_rows #(.PIPE_STAGES(2)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .inverse(inverse),
    .data_in(data_in), .out_valid(ov2), .data_out(do2));

  // Reference: each row is a 32-bit word rotated by r bytes (left forward, right inverse).
  function automatic logic [127:0] model(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    logic [31:0] w, rw;
    logic [63:0] ww;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      w = {x[127 - 8 * r -: 8], x[95 - 8 * r -: 8], x[63 - 8 * r -: 8], x[31 - 8 * r -: 8]};
      ww = {w, w};
      rw = inv ? ww[31 + 8 * r -: 32] : ww[63 - 8 * r -: 32];
      y[127 - 8 * r -: 8] = rw[31:24];
      y[95 - 8 * r -: 8]  = rw[23:16];
      y[63 - 8 * r -: 8]  = rw[15:8];
      y[31 - 8 * r -: 8]  = rw[7:0];
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m1v <= 1'b0; m2v <= 1'b0; m1d <= '0; m2d <= '0;
    end else begin
      m1v <= in_valid;
      m2v <= m1v;
      if (in_valid) m1d <= model(data_in, inverse);
      if (m1v) m2d <= m1d;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("mon_valid1", {127'b0, ov1}, {127'b0, m1v});
      chk("mon_valid2", {127'b0, ov2}, {127'b0, m2v});
      if (m1v) chk("mon_data1", do1, m1d);
      if (m2v) chk("mon_data2", do2, m2d);
    end
  end

  task automatic step(input logic r, input logic v, input logic inv, input logic [127:0] d);
    rst = r; in_valid = v; inverse = inv; data_in = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [127:0] x, y;
    logic m;
    tbl[0] = '{1'b0, 128'h0123456789ABCDEF0123456789ABCDEF, 128'h01AB45EF8923CD6701AB45EF8923CD67};
    tbl[1] = '{1'b1, 128'h01AB45EF8923CD6701AB45EF8923CD67, 128'h0123456789ABCDEF0123456789ABCDEF};
    tbl[2] = '{1'b0, 128'h000102030405060708090A0B0C0D0E0F, 128'h00050A0F04090E03080D02070C01060B};
    tbl[3] = '{1'b1, 128'h00050A0F04090E03080D02070C01060B, 128'h000102030405060708090A0B0C0D0E0F};
    tbl[4] = '{1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tbl[5] = '{1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230};

    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    armed = 1'b1;
    chk("reset_valid1", {127'b0, ov1}, 128'd0);
    chk("reset_valid2", {127'b0, ov2}, 128'd0);
    chk("reset_data1", do1, 128'd0);
    chk("reset_data2", do2, 128'd0);

    // Back-to-back mixed-mode vectors; stage-2 instance lags by one beat.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, tbl[i].inv, tbl[i].din);
      chk($sformatf("vec%0d_valid1", i), {127'b0, ov1}, 128'd1);
      chk($sformatf("vec%0d_data1", i), do1, tbl[i].exp);
      if (i > 0) chk($sformatf("vec%0d_data2", i - 1), do2, tbl[i - 1].exp);
    end
    step(0, 0, 0, '0);
    chk("tail_valid1", {127'b0, ov1}, 128'd0);
    chk("tail_valid2", {127'b0, ov2}, 128'd1);
    chk("tail_data2", do2, tbl[5].exp);
    step(0, 0, 0, '0);
    chk("drain_valid2", {127'b0, ov2}, 128'd0);

    // Reset while a beat is in flight in the 2-stage pipe.
    step(0, 1, 0, tbl[4].din);
    step(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0);
      chk("flush_valid2", {127'b0, ov2}, 128'd0);
      chk("flush_data2", do2, 128'd0);
      chk("flush_data1", do1, 128'd0);
    end

    // A beat presented during reset is dropped.
    step(1, 1, 0, tbl[2].din);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0);
      chk("drop_valid1", {127'b0, ov1}, 128'd0);
      chk("drop_valid2", {127'b0, ov2}, 128'd0);
    end

    // Latency: single beat visible after exactly 1 and 2 cycles.
    step(0, 1, 0, tbl[4].din);
    chk("lat_valid1", {127'b0, ov1}, 128'd1);
    chk("lat_data1", do1, tbl[4].exp);
    chk("lat_early2", {127'b0, ov2}, 128'd0);
    step(0, 0, 0, '0);
    chk("lat_valid2", {127'b0, ov2}, 128'd1);
    chk("lat_data2", do2, tbl[4].exp);
    chk("lat_gone1", {127'b0, ov1}, 128'd0);

    // Random chained pairs: forward-then-inverse (or reverse) must reproduce the input.
    for (int i = 0; i < 500; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      y = model(x, m);
      step(0, 1, m, x);
      chk("rand_first", do1, y);
      step(0, 1, ~m, y);
      chk("rand_chain", do1, x);
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, '0);
    end
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_rows.md
Name: shift_rows

Overview:
- Registered AES ShiftRows / InvShiftRows permutation on a 128-bit state.
- A per-beat mode bit selects the forward (encrypt) or inverse (decrypt) permutation.
- Sits in the AES round datapath between SubBytes/InvSubBytes and MixColumns/AddRoundKey.
- Pure byte permutation: no arithmetic, no key material. Latency is fixed and configurable, with full throughput.

Parameters:
- PIPE_STAGES, default 1: number of register stages from input to output. Legal values are 1 and 2; any other value is an elaboration error.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  data_in/inverse carry a beat this cycle
- inverse  input  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with the beat
- data_in  input  128  AES state in
- out_valid  output  1  data_out holds a result this cycle
- data_out  output  128  permuted state

Behaviour:
- Byte indexing: byte k (k = 0..15) is data[127-8k -: 8]. State is column-major: byte k = s(r,c) with r = k mod 4, c = k div 4.
- Forward permutation: s'(r,c) = s(r,(c+r) mod 4). Row 0 is unchanged; rows 1, 2, 3 rotate left by 1, 2, 3 columns.
- Inverse permutation: s'(r,c) = s(r,(c-r) mod 4). Rows 1, 2, 3 rotate right by 1, 2, 3 columns.
- Inverse(Forward(x)) = x and Forward(Inverse(x)) = x for every x.
- Permutation is combinational, selected by inverse, and then registered.
- With PIPE_STAGES=1: data_out and out_valid update on the clock edge that samples in_valid, so they are visible one cycle after input.
- With PIPE_STAGES=2: a second register stage is added after the first; latency is 2 cycles.
- Data and valid pipeline stages always advance together.
- Throughput: one beat per cycle. There is no back-pressure and no stall input.
- When in_valid=0 at a stage's input, that stage's data register holds its previous value and only its valid bit clears. out_valid=0 means data_out is don't-care; the bench checks data only when out_valid=1.
- The inverse bit travels with its beat. Mixed forward/inverse beats in consecutive cycles each use their own mode.
- Reset: when rst=1 at a rising edge, every stage's data register goes to 128'h0 and its valid bit to 0. After reset, data_out = 0 and out_valid = 0.
- Reset overrides in_valid in the same cycle, so a beat presented during reset is dropped.
- Reset mid-operation flushes every in-flight beat; none appear after rst deasserts.
- The first beat accepted after reset deassertion emerges exactly PIPE_STAGES cycles later.
- No X propagation from the control path: out_valid is always driven 0 or 1 after the first reset.

Test Plan:
1. Forward, PIPE_STAGES=1: rst for 2 cycles, then data_in=0123456789ABCDEF0123456789ABCDEF, inverse=0, in_valid=1 for 1 cycle -> next cycle out_valid=1 and data_out=01AB45EF8923CD6701AB45EF8923CD67.
2. Inverse round-trip: feed 01AB45EF8923CD6701AB45EF8923CD67 with inverse=1 -> data_out=0123456789ABCDEF0123456789ABCDEF, equal to the original input.
3. Distinct bytes and FIPS-197 vectors:
   - data_in=000102030405060708090A0B0C0D0E0F, inverse=0 -> 00050A0F04090E03080D02070C01060B; that value with inverse=1 -> 000102...0F.
   - d42711aee0bf98f1b8b45de51e415230, inverse=0 -> d4bf5d30e0b452aeb84111f11e2798e5.
4. Back-to-back mixed modes: 4 consecutive beats alternating inverse=0/1 -> 4 consecutive out_valid=1 cycles, each result matching its own mode; out_valid drops the cycle after the last beat emerges.
5. Reset behaviour:
   - Assert rst while a beat is in flight (PIPE_STAGES=2, rst in the cycle after in_valid) -> out_valid stays 0 and data_out=0 until a new beat is accepted.
   - in_valid=1 during rst -> that beat never appears.
6. Latency sweep: for PIPE_STAGES=1 and 2, a single beat appears exactly 1 or 2 cycles later respectively. 1000 random beats with random mode -> every output equals the software model, and a forward-then-inverse chained pair reproduces each input.
